// File: rtl/hsv_convert_ctrl.sv
// RGB to 8-bit HSV sequencer built around one shared 16/8 restoring divider.
// Latency: 33 edges from acceptance to o_valid (2 edges when max == min).
// Backpressure: one pixel in flight; o_in_ready only in IDLE, result held in OUT until i_ready.
module hsv_convert_ctrl #(
  parameter logic [7:0] HUE_SCALE  = 8'd43,
  parameter logic [7:0] HUE_BASE_G = 8'd85,
  parameter logic [7:0] HUE_BASE_B = 8'd171
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_R,
  input  logic [7:0] i_G,
  input  logic [7:0] i_B,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_H,
  output logic [7:0] o_S,
  output logic [7:0] o_V,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    DIV_S = 3'd2,
    DIV_H = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Captured pixel
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // Values carried from CALC into the hue division
  logic [7:0] delta_q, delta_d;
  logic [7:0] n_abs_q, n_abs_d;
  logic       n_neg_q, n_neg_d;
  logic [7:0] base_q, base_d;

  // Divider: partial remainder, dividend/quotient shift register, divisor, step count
  logic [7:0]  rem_q, rem_d;
  logic [15:0] dq_q, dq_d;
  logic [7:0]  dvs_q, dvs_d;
  logic [3:0]  cnt_q, cnt_d;

  // Result registers
  logic [7:0] h_q, h_d, s_q, s_d, v_q, v_d;
  logic       vld_q, vld_d;

  // CALC combinational results
  logic [7:0] max_c, min_c, delta_c, base_c, hue_a_c, hue_b_c, n_abs_c;
  logic       n_neg_c;

  // Divider step combinational results
  logic [8:0]  rem_sh_c;
  logic        ge_c;
  logic [7:0]  rem_nx_c;
  logic [15:0] q_nx_c;
  logic [15:0] hue_prod_c;

  // Extrema, delta and the signed hue numerator (as sign + magnitude) of the captured pixel
  always_comb begin
    max_c   = b_q;
    base_c  = HUE_BASE_B;
    hue_a_c = r_q;
    hue_b_c = g_q;
    if (r_q >= g_q && r_q >= b_q) begin
      max_c   = r_q;
      base_c  = 8'd0;
      hue_a_c = g_q;
      hue_b_c = b_q;
    end else if (g_q >= b_q) begin
      max_c   = g_q;
      base_c  = HUE_BASE_G;
      hue_a_c = b_q;
      hue_b_c = r_q;
    end
    min_c = r_q;
    if (g_q < min_c) min_c = g_q;
    if (b_q < min_c) min_c = b_q;
    delta_c = max_c - min_c;
    // n = a - b lies in -255..255; keep it as a sign bit and an 8-bit magnitude
    n_neg_c = (hue_a_c < hue_b_c);
    n_abs_c = n_neg_c ? (hue_b_c - hue_a_c) : (hue_a_c - hue_b_c);
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh_c   = {rem_q, dq_q[15]};
    ge_c       = (rem_sh_c >= {1'b0, dvs_q});
    rem_nx_c   = ge_c ? 8'(rem_sh_c - {1'b0, dvs_q}) : rem_sh_c[7:0];
    q_nx_c     = {dq_q[14:0], ge_c};
    hue_prod_c = 16'(n_abs_q) * 16'(HUE_SCALE);
  end

  // Next-state and datapath updates; every register holds unless its state acts on it
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    delta_d = delta_q;
    n_abs_d = n_abs_q;
    n_neg_d = n_neg_q;
    base_d  = base_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    s_d     = s_q;
    v_d     = v_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          r_d     = i_R;
          g_d     = i_G;
          b_d     = i_B;
          state_d = CALC;
        end
      end
      CALC: begin
        v_d = max_c;
        if (delta_c == 8'd0) begin
          h_d     = 8'd0;
          s_d     = 8'd0;
          state_d = OUT;
        end else begin
          dq_d    = {delta_c, 8'h00};
          rem_d   = 8'd0;
          dvs_d   = max_c;
          cnt_d   = 4'd0;
          delta_d = delta_c;
          n_abs_d = n_abs_c;
          n_neg_d = n_neg_c;
          base_d  = base_c;
          state_d = DIV_S;
        end
      end
      DIV_S: begin
        rem_d = rem_nx_c;
        dq_d  = q_nx_c;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Quotient reaches 256 when min == 0; clamp rather than wrap
          s_d     = (|q_nx_c[15:8]) ? 8'hFF : q_nx_c[7:0];
          dq_d    = hue_prod_c;
          rem_d   = 8'd0;
          dvs_d   = delta_q;
          cnt_d   = 4'd0;
          state_d = DIV_H;
        end
      end
      DIV_H: begin
        rem_d = rem_nx_c;
        dq_d  = q_nx_c;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // |n| <= delta, so the quotient never exceeds HUE_SCALE and fits in 8 bits
          h_d     = n_neg_q ? (base_q - q_nx_c[7:0]) : (base_q + q_nx_c[7:0]);
          vld_d   = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        // The max == min shortcut raises valid one edge after entering OUT
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (i_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any pixel in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath, divider and result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
      delta_q <= 8'd0;
      n_abs_q <= 8'd0;
      n_neg_q <= 1'b0;
      base_q  <= 8'd0;
      rem_q   <= 8'd0;
      dq_q    <= 16'd0;
      dvs_q   <= 8'd0;
      cnt_q   <= 4'd0;
      h_q     <= 8'd0;
      s_q     <= 8'd0;
      v_q     <= 8'd0;
      vld_q   <= 1'b0;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      delta_q <= delta_d;
      n_abs_q <= n_abs_d;
      n_neg_q <= n_neg_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      s_q     <= s_d;
      v_q     <= v_d;
      vld_q   <= vld_d;
    end
  end

  assign o_in_ready = (state_q == IDLE);
  assign o_busy     = (state_q != IDLE);
  assign o_valid    = vld_q;
  assign o_H        = h_q;
  assign o_S        = s_q;
  assign o_V        = v_q;

endmodule

// File: tb/tb_hsv_convert_ctrl.sv
// Directed bench for hsv_convert_ctrl: hand-computed HSV vectors, latency,
// backpressure hold and mid-conversion reset recovery.
module tb_hsv_convert_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
  logic       o_in_ready, o_valid, o_busy;
  logic [7:0] h, s, v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hsv_convert_ctrl dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_in_ready(o_in_ready),
    .i_R       (r),
    .i_G       (g),
    .i_B       (b),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_H       (h),
    .o_S       (s),
    .o_V       (v),
    .o_busy    (o_busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer a pixel (accepted at the next edge), then count edges until o_valid
  task automatic run_to_out(input string tag, input logic [7:0] rr, gg, bb,
                            input logic [7:0] eh, es, ev, input int elat);
    int lat;
    chk({tag, " in_ready"}, {15'd0, o_in_ready}, 16'd1);
    r = rr; g = gg; b = bb; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    chk({tag, " busy"}, {15'd0, o_busy}, 16'd1);
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 16'(lat), 16'(elat));
    chk({tag, " H"}, {8'd0, h}, {8'd0, eh});
    chk({tag, " S"}, {8'd0, s}, {8'd0, es});
    chk({tag, " V"}, {8'd0, v}, {8'd0, ev});
  endtask

  task automatic transfer(input string tag);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk({tag, " valid after xfer"}, {15'd0, o_valid}, 16'd0);
    chk({tag, " ready after xfer"}, {15'd0, o_in_ready}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", {15'd0, o_valid}, 16'd0);
    chk("rst in_ready", {15'd0, o_in_ready}, 16'd1);
    chk("rst busy", {15'd0, o_busy}, 16'd0);
    chk("rst H", {8'd0, h}, 16'd0);
    chk("rst S", {8'd0, s}, 16'd0);
    chk("rst V", {8'd0, v}, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // General conversions
    run_to_out("p200_100_50", 8'd200, 8'd100, 8'd50, 8'd14, 8'd192, 8'd200, 33);
    transfer("p200_100_50");
    run_to_out("p10_20_30", 8'd10, 8'd20, 8'd30, 8'd150, 8'd170, 8'd30, 33);
    transfer("p10_20_30");
    run_to_out("p0_255_0", 8'd0, 8'd255, 8'd0, 8'd85, 8'd255, 8'd255, 33);
    transfer("p0_255_0");
    run_to_out("p255_0_255", 8'd255, 8'd0, 8'd255, 8'd213, 8'd255, 8'd255, 33);
    transfer("p255_0_255");

    // max == min shortcut
    run_to_out("gray", 8'd128, 8'd128, 8'd128, 8'd0, 8'd0, 8'd128, 2);
    transfer("gray");
    run_to_out("black", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2);
    transfer("black");

    // Backpressure: hold result 10 cycles while the source keeps changing
    run_to_out("p100_200_150", 8'd100, 8'd200, 8'd150, 8'd106, 8'd128, 8'd200, 33);
    for (int i = 0; i < 10; i++) begin
      i_valid = ~i_valid;
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      chk("hold valid", {15'd0, o_valid}, 16'd1);
      chk("hold in_ready", {15'd0, o_in_ready}, 16'd0);
      chk("hold H", {8'd0, h}, 16'd106);
      chk("hold S", {8'd0, s}, 16'd128);
      chk("hold V", {8'd0, v}, 16'd200);
    end
    // Release with a new pixel already offered; it must go in one edge later
    r = 8'd0; g = 8'd0; b = 8'd255; i_valid = 1'b1;
    transfer("release");
    run_to_out("p0_0_255", 8'd0, 8'd0, 8'd255, 8'd171, 8'd255, 8'd255, 33);
    transfer("p0_0_255");

    // Reset in the middle of the hue division
    chk("pre-abort in_ready", {15'd0, o_in_ready}, 16'd1);
    r = 8'd200; g = 8'd100; b = 8'd50; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("mid DIV_H busy", {15'd0, o_busy}, 16'd1);
    chk("mid DIV_H valid", {15'd0, o_valid}, 16'd0);
    chk("mid DIV_H V", {8'd0, v}, 16'd200);
    rst_n = 1'b0;
    #1;
    chk("abort valid", {15'd0, o_valid}, 16'd0);
    chk("abort H", {8'd0, h}, 16'd0);
    chk("abort S", {8'd0, s}, 16'd0);
    chk("abort V", {8'd0, v}, 16'd0);
    chk("abort busy", {15'd0, o_busy}, 16'd0);
    chk("abort in_ready", {15'd0, o_in_ready}, 16'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_to_out("p50_100_200", 8'd50, 8'd100, 8'd200, 8'd157, 8'd192, 8'd200, 33);
    transfer("p50_100_200");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
